// File: rtl/sincronizador_vga.sv
// VGA raster timing generator: free-running h/v counters on the pixel clock with
// registered sync, visible-area, coordinate and end-of-line/frame outputs.
module sincronizador_vga #(
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33,
   parameter bit          SYNC_POL  = 1'b0,
   parameter int unsigned CNT_W     = 10
) (
   input  logic             clk_VGA,
   input  logic             reset,
   input  logic             habilitar,
   output logic             hsync,
   output logic             vsync,
   output logic             video_on,
   output logic [CNT_W-1:0] pixel_x,
   output logic [CNT_W-1:0] pixel_y,
   output logic             fin_linea,
   output logic             fin_cuadro
);

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   // One extra bit so bounds equal to 2^CNT_W still compare correctly.
   localparam logic [CNT_W:0] HVis     = (CNT_W+1)'(H_VISIBLE);
   localparam logic [CNT_W:0] HsStart  = (CNT_W+1)'(H_VISIBLE + H_FRONT);
   localparam logic [CNT_W:0] HsEnd    = (CNT_W+1)'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [CNT_W:0] VVis     = (CNT_W+1)'(V_VISIBLE);
   localparam logic [CNT_W:0] VsStart  = (CNT_W+1)'(V_VISIBLE + V_FRONT);
   localparam logic [CNT_W:0] VsEnd    = (CNT_W+1)'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic [CNT_W-1:0] HLast  = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] VLast  = CNT_W'(V_TOTAL - 1);

   localparam logic SyncAct   = SYNC_POL;
   localparam logic SyncInact = ~SYNC_POL;

   logic [CNT_W-1:0] hcount_q, hcount_d;
   logic [CNT_W-1:0] vcount_q, vcount_d;

   logic             hsync_q, hsync_d;
   logic             vsync_q, vsync_d;
   logic             video_on_q, video_on_d;
   logic [CNT_W-1:0] pixel_x_q, pixel_y_q;
   logic             fin_linea_q, fin_linea_d;
   logic             fin_cuadro_q, fin_cuadro_d;

   logic [CNT_W:0] h_ext, v_ext;
   logic           h_last, v_last;

   assign h_ext  = {1'b0, hcount_q};
   assign v_ext  = {1'b0, vcount_q};
   assign h_last = (hcount_q == HLast);
   assign v_last = (vcount_q == VLast);

   always_comb begin
      hcount_d = hcount_q;
      vcount_d = vcount_q;
      if (habilitar) begin
         if (h_last) begin
            hcount_d = '0;
            vcount_d = v_last ? '0 : vcount_q + CNT_W'(1);
         end else begin
            hcount_d = hcount_q + CNT_W'(1);
         end
      end
   end

   // Outputs decode the position before the edge, giving one uniform cycle of latency.
   always_comb begin
      video_on_d   = (h_ext < HVis) && (v_ext < VVis);
      hsync_d      = ((h_ext >= HsStart) && (h_ext < HsEnd)) ? SyncAct : SyncInact;
      vsync_d      = ((v_ext >= VsStart) && (v_ext < VsEnd)) ? SyncAct : SyncInact;
      fin_linea_d  = h_last;
      fin_cuadro_d = h_last && v_last;
   end

   always_ff @(posedge clk_VGA or negedge reset) begin
      if (!reset) begin
         hcount_q     <= '0;
         vcount_q     <= '0;
         hsync_q      <= SyncInact;
         vsync_q      <= SyncInact;
         video_on_q   <= 1'b0;
         pixel_x_q    <= '0;
         pixel_y_q    <= '0;
         fin_linea_q  <= 1'b0;
         fin_cuadro_q <= 1'b0;
      end else if (habilitar) begin
         hcount_q     <= hcount_d;
         vcount_q     <= vcount_d;
         hsync_q      <= hsync_d;
         vsync_q      <= vsync_d;
         video_on_q   <= video_on_d;
         pixel_x_q    <= hcount_q;
         pixel_y_q    <= vcount_q;
         fin_linea_q  <= fin_linea_d;
         fin_cuadro_q <= fin_cuadro_d;
      end
   end

   assign hsync      = hsync_q;
   assign vsync      = vsync_q;
   assign video_on   = video_on_q;
   assign pixel_x    = pixel_x_q;
   assign pixel_y    = pixel_y_q;
   assign fin_linea  = fin_linea_q;
   assign fin_cuadro = fin_cuadro_q;

endmodule

// File: tb/tb_sincronizador_vga.sv
// Scoreboard bench for sincronizador_vga: a small-raster instance (active-low sync) and a
// SYNC_POL=1 / H_VISIBLE=320 instance, both compared every cycle against a raster model.
module tb_sincronizador_vga;

   typedef struct packed {
      logic       hs;
      logic       vs;
      logic       von;
      logic       fl;
      logic       fc;
      logic [9:0] x;
      logic [9:0] y;
   } outs_t;

   // Per-instance timing: {H_VIS, H_FP, H_SYNC, H_BP, V_VIS, V_FP, V_SYNC, V_BP}
   int unsigned hv [2] = '{20, 320};
   int unsigned hf [2] = '{3, 16};
   int unsigned hw [2] = '{5, 96};
   int unsigned hb [2] = '{4, 48};
   int unsigned vv [2] = '{12, 480};
   int unsigned vf [2] = '{2, 10};
   int unsigned vw [2] = '{2, 2};
   int unsigned vb [2] = '{3, 33};
   bit          pol [2] = '{1'b0, 1'b1};

   localparam int unsigned HT0   = 32;
   localparam int unsigned FRAME = 32 * 19;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic habilitar = 1'b1;

   logic       hs0, vs0, von0, fl0, fc0, hs1, vs1, von1, fl1, fc1;
   logic [9:0] x0, y0, x1, y1;

   always #5 clk = ~clk;

   sincronizador_vga #(
      .H_VISIBLE(20), .H_FRONT(3), .H_SYNC(5), .H_BACK(4),
      .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
      .SYNC_POL(1'b0), .CNT_W(10)
   ) u_dut0 (
      .clk_VGA(clk), .reset(reset), .habilitar(habilitar),
      .hsync(hs0), .vsync(vs0), .video_on(von0), .pixel_x(x0), .pixel_y(y0),
      .fin_linea(fl0), .fin_cuadro(fc0)
   );

   sincronizador_vga #(
      .H_VISIBLE(320), .SYNC_POL(1'b1)
   ) u_dut1 (
      .clk_VGA(clk), .reset(reset), .habilitar(habilitar),
      .hsync(hs1), .vsync(vs1), .video_on(von1), .pixel_x(x1), .pixel_y(y1),
      .fin_linea(fl1), .fin_cuadro(fc1)
   );

   outs_t obs [2];
   assign obs[0] = {hs0, vs0, von0, fl0, fc0, x0, y0};
   assign obs[1] = {hs1, vs1, von1, fl1, fc1, x1, y1};

   int checks = 0;
   int failures = 0;

   int    mh [2];
   int    mv [2];
   outs_t last [2];
   outs_t sb0 [$];
   outs_t sb1 [$];

   int cnt_von, cnt_hs, cnt_fl, cnt_fc, cnt_vs, run_vs, max_vs;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic outs_t rst_outs(input int c);
      outs_t o;
      o     = '0;
      o.hs  = ~pol[c];
      o.vs  = ~pol[c];
      return o;
   endfunction

   function automatic outs_t dec(input int h, input int v, input int c);
      outs_t o;
      int    ht, vt;
      ht    = int'(hv[c] + hf[c] + hw[c] + hb[c]);
      vt    = int'(vv[c] + vf[c] + vw[c] + vb[c]);
      o.x   = 10'(h);
      o.y   = 10'(v);
      o.von = (h < int'(hv[c])) && (v < int'(vv[c]));
      o.hs  = (h >= int'(hv[c] + hf[c]) && h < int'(hv[c] + hf[c] + hw[c])) ? pol[c] : ~pol[c];
      o.vs  = (v >= int'(vv[c] + vf[c]) && v < int'(vv[c] + vf[c] + vw[c])) ? pol[c] : ~pol[c];
      o.fl  = (h == ht - 1);
      o.fc  = (h == ht - 1) && (v == vt - 1);
      return o;
   endfunction

   task automatic advance(input int c);
      mh[c]++;
      if (mh[c] == int'(hv[c] + hf[c] + hw[c] + hb[c])) begin
         mh[c] = 0;
         mv[c]++;
         if (mv[c] == int'(vv[c] + vf[c] + vw[c] + vb[c])) mv[c] = 0;
      end
   endtask

   task automatic clear_stats();
      cnt_von = 0; cnt_hs = 0; cnt_fl = 0; cnt_fc = 0; cnt_vs = 0; run_vs = 0; max_vs = 0;
   endtask

   // Push expected outputs for the coming edge, then pop and compare after it.
   task automatic tick();
      bit    en;
      outs_t e;
      en = reset && habilitar;
      for (int c = 0; c < 2; c++) begin
         if (!reset) begin
            mh[c]   = 0;
            mv[c]   = 0;
            last[c] = rst_outs(c);
         end
         if (en) begin
            last[c] = dec(mh[c], mv[c], c);
            advance(c);
         end
         if (c == 0) sb0.push_back(last[c]);
         else        sb1.push_back(last[c]);
      end
      @(posedge clk);
      #1;
      e = sb0.pop_front();
      check("out0", 32'(obs[0]), 32'(e));
      e = sb1.pop_front();
      check("out1", 32'(obs[1]), 32'(e));
      cnt_von += int'(von0);
      cnt_hs  += int'(!hs0);
      cnt_fl  += int'(fl0);
      cnt_fc  += int'(fc0);
      if (!vs0) begin
         cnt_vs++;
         run_vs++;
         if (run_vs > max_vs) max_vs = run_vs;
      end else begin
         run_vs = 0;
      end
   endtask

   task automatic run_frame();
      clear_stats();
      for (int i = 0; i < FRAME; i++) begin
         tick();
         if (i == HT0 - 1) begin
            check("line_video_on", 32'(cnt_von), 32'd20);
            check("line_hsync", 32'(cnt_hs), 32'd5);
            check("line_fin_linea", 32'(cnt_fl), 32'd1);
         end
      end
      check("frame_video_on", 32'(cnt_von), 32'd240);
      check("frame_vsync", 32'(cnt_vs), 32'd64);
      check("frame_vsync_run", 32'(max_vs), 32'd64);
      check("frame_fin_linea", 32'(cnt_fl), 32'd19);
      check("frame_fin_cuadro", 32'(cnt_fc), 32'd1);
      check("frame_last_fc", 32'(fc0), 32'd1);
      tick();
      check("wrap_xy", {x0, y0}, 20'd0);
   endtask

   task automatic wait_pos(input int x, input int y);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 2 * FRAME && !hit; i++) begin
         tick();
         hit = (int'(x0) == x) && (int'(y0) == y);
      end
      check("wait_pos_reached", 32'(hit), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #3;
      for (int i = 0; i < 4; i++) tick();
      check("rst_hsync", 32'(hs0), 32'd1);
      check("rst_vsync", 32'(vs0), 32'd1);
      check("rst_hsync_pos1", 32'(hs1), 32'd0);

      reset = 1'b1;
      tick();
      check("first_xy", {x0, y0}, 20'd0);
      check("first_video_on", 32'(von0), 32'd1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      run_frame();

      wait_pos(10, 5);
      habilitar = 1'b0;
      for (int i = 0; i < 50; i++) tick();
      check("hold_xy", {x0, y0}, {10'd10, 10'd5});
      habilitar = 1'b1;
      tick();
      check("resume_xy", {x0, y0}, {10'd11, 10'd5});

      wait_pos(25, 15);
      check("pre_rst_hsync", 32'(hs0), 32'd0);
      check("pre_rst_vsync", 32'(vs0), 32'd0);
      #2;
      reset = 1'b0;
      #1;
      check("async_rst_out", 32'(obs[0]), 32'(rst_outs(0)));
      check("async_rst_out1", 32'(obs[1]), 32'(rst_outs(1)));
      tick();
      tick();
      reset = 1'b1;
      run_frame();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
